// File: rtl/spi_flash_sched.sv
// Two-requester SPI flash transaction scheduler: round-robin grant, then CMD/ADDR/DATA byte slots of DIV clocks each.
// Define SPI_SCHED_WREN_EN to precede every write with a WREN slot and a deselected GAP slot.
module spi_flash_sched #(
  parameter int unsigned DIV = 4
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic        done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        s_css,
  output logic        s_stb,
  output logic [7:0]  s_mosi,
  input  logic [7:0]  s_miso
);

  if (DIV < 2 || DIV > 255) begin : g_div_check
    $error("spi_flash_sched: DIV must be in 2..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef SPI_SCHED_WREN_EN
  localparam logic [7:0] OP_WREN  = 8'h06;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SPI_SCHED_WREN_EN
    S_WREN,
    S_GAP,
`endif
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        css_q, css_d;
  logic        stb_q, stb_d;
  logic [7:0]  mosi_q, mosi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] stage_q, stage_d;
  logic        wr_q, wr_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_q, last_d;

  logic slot_end;
  logic pick1;
  logic sel_wr;

  assign slot_end = (cnt_q == CNT_LAST);
  // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
  assign pick1    = req1 & (~req0 | ~last_q);
  assign sel_wr   = pick1 ? wr1 : wr0;

  function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] i);
    case (i)
      2'd0:    addr_byte = a[23:16];
      2'd1:    addr_byte = a[15:8];
      default: addr_byte = a[7:0];
    endcase
  endfunction

  function automatic logic [7:0] data_byte(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    data_byte = d[31:24];
      2'd1:    data_byte = d[23:16];
      2'd2:    data_byte = d[15:8];
      default: data_byte = d[7:0];
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = slot_end ? '0 : cnt_q + 8'd1;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    css_d   = css_q;
    stb_d   = 1'b0;
    mosi_d  = mosi_q;
    rdata_d = rdata_q;
    stage_d = stage_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (req0 | req1) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          wr_d    = sel_wr;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          busy_d  = 1'b1;
          css_d   = 1'b0;
          stb_d   = 1'b1;
`ifdef SPI_SCHED_WREN_EN
          if (sel_wr) begin
            state_d = S_WREN;
            mosi_d  = OP_WREN;
          end else begin
            state_d = S_CMD;
            mosi_d  = OP_READ;
          end
`else
          state_d = S_CMD;
          mosi_d  = sel_wr ? OP_WRITE : OP_READ;
`endif
        end
      end

`ifdef SPI_SCHED_WREN_EN
      S_WREN: begin
        if (slot_end) begin
          state_d = S_GAP;
          css_d   = 1'b1;
          mosi_d  = '0;
        end
      end

      S_GAP: begin
        if (slot_end) begin
          state_d = S_CMD;
          css_d   = 1'b0;
          stb_d   = 1'b1;
          mosi_d  = wr_q ? OP_WRITE : OP_READ;
        end
      end
`endif

      S_CMD: begin
        if (slot_end) begin
          state_d = S_ADDR;
          idx_d   = '0;
          stb_d   = 1'b1;
          mosi_d  = addr_byte(addr_q, 2'd0);
        end
      end

      S_ADDR: begin
        if (slot_end) begin
          stb_d = 1'b1;
          if (idx_q == 2'd2) begin
            state_d = S_DATA;
            idx_d   = '0;
            mosi_d  = wr_q ? data_byte(wdata_q, 2'd0) : '0;
          end else begin
            idx_d  = idx_q + 2'd1;
            mosi_d = addr_byte(addr_q, idx_q + 2'd1);
          end
        end
      end

      S_DATA: begin
        if (!wr_q && slot_end) begin
          case (idx_q)
            2'd0:    stage_d[31:24] = s_miso;
            2'd1:    stage_d[23:16] = s_miso;
            2'd2:    stage_d[15:8]  = s_miso;
            default: stage_d[7:0]   = s_miso;
          endcase
        end
        if (slot_end) begin
          if (idx_q == 2'd3) begin
            // stage_d already holds the final byte sampled this cycle
            state_d = S_DONE;
            done_d  = 1'b1;
            css_d   = 1'b1;
            mosi_d  = '0;
            cnt_d   = '0;
            last_d  = gnt_q[1];
            if (!wr_q) rdata_d = stage_d;
          end else begin
            idx_d  = idx_q + 2'd1;
            stb_d  = 1'b1;
            mosi_d = wr_q ? data_byte(wdata_q, idx_q + 2'd1) : '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        css_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      css_q   <= 1'b1;
      stb_q   <= 1'b0;
      mosi_q  <= '0;
      rdata_q <= '0;
      stage_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      css_q   <= css_d;
      stb_q   <= stb_d;
      mosi_q  <= mosi_d;
      rdata_q <= rdata_d;
      stage_q <= stage_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign s_css  = css_q;
  assign s_stb  = stb_q;
  assign s_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_sched.sv
// Scoreboard bench for spi_flash_sched: stimulus queues expected transactions, a monitor checks each done.
// Expectations for writes follow SPI_SCHED_WREN_EN when it is defined.
module tb_spi_flash_sched;

  logic        p_clk = 1'b0;
  logic        p_reset;
  logic        req0, req1, wr0, wr1;
  logic [23:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt;
  logic        done;
  logic [31:0] rdata;
  logic        busy, s_css, s_stb;
  logic [7:0]  s_mosi, s_miso;

  spi_flash_sched #(.DIV(4)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .s_css(s_css), .s_stb(s_stb), .s_mosi(s_mosi), .s_miso(s_miso)
  );

  always #5 p_clk = ~p_clk;

  int unsigned cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

`ifdef SPI_SCHED_WREN_EN
  localparam logic [79:0] W_MOSI = 80'h06_02_00ABCD_DEADBEEF;
  localparam int unsigned W_NB = 9, W_LAT = 40, W_CSS = 4;
`else
  localparam logic [79:0] W_MOSI = 80'h02_00ABCD_DEADBEEF;
  localparam int unsigned W_NB = 8, W_LAT = 32, W_CSS = 0;
`endif

  typedef struct packed {
    logic [1:0]  gnt;
    logic [79:0] mosi;
    int unsigned nb;
    int unsigned lat;
    int unsigned css_hi;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] miso_word = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [79:0] m, input int unsigned nb,
                      input int unsigned lat, input int unsigned css, input logic [31:0] rd);
    exp_t e;
    e.gnt = g; e.mosi = m; e.nb = nb; e.lat = lat; e.css_hi = css; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Flash model: returns miso_word bytes MSB first in the four data slots
  initial begin
    int unsigned k;
    k = 0;
    s_miso = 8'h00;
    forever begin
      @(negedge p_clk);
      if (p_reset || !busy) k = 0;
      else if (s_stb) begin
        if (k >= 4 && k < 8) s_miso = miso_word[8*(7-k) +: 8];
        else s_miso = 8'hEE;
        k++;
      end
    end
  end

  // Monitor: collects the byte stream of each transaction and scores it at done
  initial begin
    bit          active;
    logic [1:0]  g0;
    int unsigned gcyc, nb, css_hi;
    logic [79:0] seen;
    bit          gchg;
    exp_t        e;
    active = 0; g0 = '0; gcyc = 0; nb = 0; css_hi = 0; seen = '0; gchg = 0;
    forever begin
      @(negedge p_clk);
      if (p_reset) begin
        active = 0;
        continue;
      end
      if (!active && gnt != 2'b00) begin
        active = 1; g0 = gnt; gcyc = cyc; nb = 0; seen = '0; css_hi = 0; gchg = 0;
      end
      if (active) begin
        if (gnt !== g0) gchg = 1;
        if (s_stb) begin
          seen = {seen[71:0], s_mosi};
          nb++;
        end
        if (s_css && !done) css_hi++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("gnt_first", 80'(g0), 80'(e.gnt));
          check("gnt_at_done", 80'(gnt), 80'(e.gnt));
          check("gnt_changed", 80'(gchg), 80'(0));
          check("mosi_seq", seen, e.mosi);
          check("slot_count", 80'(nb), 80'(e.nb));
          check("latency", 80'(cyc - gcyc), 80'(e.lat));
          check("css_high_cycles", 80'(css_hi), 80'(e.css_hi));
          check("rdata", 80'(rdata), 80'(e.rdata));
        end
        active = 0;
      end
    end
  end

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge p_clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
    end
  endtask

  task automatic wait_grant(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge p_clk);
      if (gnt != 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_grant_timeout: got gnt=0 expected a grant within 20 cycles", name);
    end
  endtask

  // One transaction on requester n; inputs are scrambled after grant to prove they are latched
  task automatic do_xact(input int n, input logic wr, input logic [23:0] a, input logic [31:0] wd,
                         input logic [31:0] miso, input logic [79:0] emosi, input int unsigned enb,
                         input int unsigned elat, input int unsigned ecss, input logic [31:0] erd,
                         input bit early_drop);
    push((n == 1) ? 2'b10 : 2'b01, emosi, enb, elat, ecss, erd);
    miso_word = miso;
    if (n == 1) begin wr1 = wr; addr1 = a; wdata1 = wd; req1 = 1'b1; end
    else        begin wr0 = wr; addr0 = a; wdata0 = wd; req0 = 1'b1; end
    wait_grant("xact");
    #1;
    if (n == 1) begin wr1 = ~wr; addr1 = ~a; wdata1 = ~wd; end
    else        begin wr0 = ~wr; addr0 = ~a; wdata0 = ~wd; end
    if (early_drop) begin
      repeat (18) @(negedge p_clk);
      #1;
      if (n == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    wait_done("xact");
    #1;
    if (n == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge p_clk);
    check("rst_gnt",   80'(gnt),    80'(0));
    check("rst_done",  80'(done),   80'(0));
    check("rst_busy",  80'(busy),   80'(0));
    check("rst_css",   80'(s_css),  80'(1));
    check("rst_stb",   80'(s_stb),  80'(0));
    check("rst_mosi",  80'(s_mosi), 80'(0));
    check("rst_rdata", 80'(rdata),  80'(0));
    #1 p_reset = 1'b0;
    @(negedge p_clk); #1;

    // Basic read on requester 0
    do_xact(0, 1'b0, 24'h123456, 32'h0, 32'hA1B2C3D4, 80'h03123456_00000000,
            8, 32, 0, 32'hA1B2C3D4, 0);

    // Write on requester 1; rdata must keep the previous read word
    do_xact(1, 1'b1, 24'h00ABCD, 32'hDEADBEEF, 32'h0, W_MOSI,
            W_NB, W_LAT, W_CSS, 32'hA1B2C3D4, 0);

    // Round robin from reset: both requesting, req0 held across all three grants
    #1 p_reset = 1'b1;
    @(negedge p_clk); #1 p_reset = 1'b0;
    @(negedge p_clk); #1;
    miso_word = 32'h11223344;
    wr0 = 1'b0; addr0 = 24'h000010; wdata0 = '0;
    wr1 = 1'b0; addr1 = 24'hFFFFFF; wdata1 = '0;
    push(2'b01, 80'h03000010_00000000, 8, 32, 0, 32'h11223344);
    push(2'b10, 80'h03FFFFFF_00000000, 8, 32, 0, 32'h11223344);
    push(2'b01, 80'h03000010_00000000, 8, 32, 0, 32'h11223344);
    req0 = 1'b1; req1 = 1'b1;
    wait_done("rr1");
    @(negedge p_clk);
    check("rr_idle_gap_gnt", 80'(gnt), 80'(0));
    @(negedge p_clk);
    check("rr_second_gnt", 80'(gnt), 80'(2'b10));
    wait_done("rr2");
    #1 req1 = 1'b0;
    wait_done("rr3");
    #1 req0 = 1'b0;

    // Reset during the third address slot abandons the read
    @(negedge p_clk); #1;
    miso_word = 32'h99999999;
    wr0 = 1'b0; addr0 = 24'h123456; req0 = 1'b1;
    wait_grant("rst_mid");
    repeat (12) @(negedge p_clk);
    check("addr2_mosi", 80'(s_mosi), 80'(8'h56));
    #1 p_reset = 1'b1;
    req0 = 1'b0;
    #1;
    check("midrst_css",  80'(s_css), 80'(1));
    check("midrst_gnt",  80'(gnt),   80'(0));
    check("midrst_busy", 80'(busy),  80'(0));
    check("midrst_done", 80'(done),  80'(0));
    @(negedge p_clk); #1 p_reset = 1'b0;
    @(negedge p_clk); #1;
    do_xact(0, 1'b0, 24'h000000, 32'h0, 32'h0F1E2D3C, 80'h03000000_00000000,
            8, 32, 0, 32'h0F1E2D3C, 0);

    // Request dropped during DATA still completes once, then no grant
    do_xact(0, 1'b0, 24'hABCDEF, 32'h0, 32'h55AA00FF, 80'h03ABCDEF_00000000,
            8, 32, 0, 32'h55AA00FF, 1);
    @(negedge p_clk);
    check("post_drop_gnt",  80'(gnt),  80'(0));
    check("post_drop_busy", 80'(busy), 80'(0));

    repeat (10) @(negedge p_clk);
    check("scoreboard_empty", 80'(sb.size()), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_sched.md
SPI_FLASH_SCHED -- requirements
Module: spi_flash_sched

Interface
REQ-001 SHALL have parameter: DIV, 4, p_clk cycles per SPI byte slot (legal 2..255).
REQ-002 SHALL have port: p_clk  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port: p_reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0/req1  in  1  requester n transaction request, level, held until its done.
REQ-005 SHALL have ports: wr0/wr1  in  1  1 = page-program write, 0 = read.
REQ-006 SHALL have ports: addr0/addr1  in  24  flash byte address.
REQ-007 SHALL have ports: wdata0/wdata1  in  32  write word.
REQ-008 SHALL have port: gnt  out  2  one-hot grant, held for whole transaction.
REQ-009 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: rdata  out  32  read word, valid at done, held until next read completes.
REQ-011 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-012 SHALL have ports: s_css  out  1  active-low chip select; s_stb  out  1  one-cycle strobe at every slot start; s_mosi  out  8  byte to flash; s_miso  in  8  byte from flash.

Function
REQ-013 SHALL implement states IDLE, (WREN, GAP when configured), CMD, ADDR, DATA, DONE.
REQ-014 IDLE: if any req high, SHALL grant, latch that requester's wr/addr/wdata, and enter CMD (or WREN) next cycle; inputs changing after grant SHALL be ignored.
REQ-015 Arbitration SHALL be round-robin: single request wins; simultaneous requests go to the requester not served last; pointer updates at DONE.
REQ-016 Each slot SHALL last exactly DIV cycles; slot counter runs 0..DIV-1; s_stb high at count 0.
REQ-017 s_mosi SHALL change only at count 0 and hold for the slot.
REQ-018 CMD: 1 slot, s_mosi = 0x03 (read) or 0x02 (write).
REQ-019 ADDR: 3 slots, addr[23:16], [15:8], [7:0].
REQ-020 DATA: 4 slots MSB byte first; write drives wdata[31:24]..[7:0]; read samples s_miso at count DIV-1 into rdata byte 3..0 (staging register, rdata updated at DONE); s_mosi = 0x00 during read DATA.
REQ-021 s_css SHALL be low during CMD, ADDR, DATA (and WREN); high in IDLE, GAP, DONE.
REQ-022 DONE: 1 cycle, done=1, gnt still held; next cycle IDLE with gnt=0.
REQ-023 Latency: request seen in IDLE at cycle t -> done at cycle t+8*DIV+1 (no WREN).
REQ-024 A req still high in IDLE after its done SHALL be treated as a new request (subject to REQ-015).
REQ-025 A req dropped mid-transaction SHALL NOT abort it; transaction completes, done pulses.

Reset
REQ-026 p_reset SHALL asynchronously force: state IDLE, gnt 0, done 0, busy 0, s_css 1, s_stb 0, s_mosi 0x00, rdata 0, slot counter 0, round-robin pointer such that requester 0 wins first.
REQ-027 Reset mid-transaction SHALL abandon it with no done pulse; s_css high in the same cycle as reset assertion.

Configuration
REQ-028 Macro SPI_SCHED_WREN_EN defined: write transactions SHALL insert a WREN slot (s_mosi 0x06, s_css low) then a GAP slot (s_css high, no s_stb) before CMD; write latency t+10*DIV+1; reads unchanged.
REQ-029 SPI_SCHED_WREN_EN undefined: WREN/GAP states absent; writes start directly at CMD.

Verification
REQ-030 DIV=4, req0 read addr 0x123456, s_miso bytes A1,B2,C3,D4 in data slots -> s_mosi 03,12,34,56,00x4; done at t+33; rdata 0xA1B2C3D4; gnt=01 throughout.
REQ-031 Both req high from reset -> gnt 01 first, then gnt 10 with no IDLE gap beyond 1 cycle; req0 held continuously with req1 -> grants alternate 01,10,01.
REQ-032 req1 write addr 0x00ABCD wdata 0xDEADBEEF, macro undefined -> s_mosi 02,00,AB,CD,DE,AD,BE,EF; done at t+33.
REQ-033 Same write with SPI_SCHED_WREN_EN -> 06, s_css high for 4 cycles, then 02,...,EF; done at t+41.
REQ-034 p_reset asserted in ADDR slot 2 -> s_css=1, gnt=0, busy=0 immediately; no done; after release req0 read completes normally.
REQ-035 req0 dropped during DATA -> transaction completes, done pulses once, next IDLE has no grant.
